// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and the hex -> seven-segment table for the display scanner.
package seg_pkg;
  typedef logic [6:0] seg_t;
  typedef enum logic {BLANK, SHOW} scan_state_t;

  localparam seg_t SEG_OFF_AH = 7'b0000000;

  // Active-high pattern, bit order {g,f,e,d,c,b,a}
  function automatic seg_t hex_to_seg_ah(input logic [3:0] nibble);
    seg_t s;
    case (nibble)
      4'h0: s = 7'b0111111;
      4'h1: s = 7'b0000110;
      4'h2: s = 7'b1011011;
      4'h3: s = 7'b1001111;
      4'h4: s = 7'b1100110;
      4'h5: s = 7'b1101101;
      4'h6: s = 7'b1111101;
      4'h7: s = 7'b0000111;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1101111;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b1111100;
      4'hC: s = 7'b0111001;
      4'hD: s = 7'b1011110;
      4'hE: s = 7'b1111001;
      default: s = 7'b1110001;
    endcase
    return s;
  endfunction
endpackage

// File: rtl/seg_scan_ctrl_decoder.sv
// Combinational nibble to active-high segment pattern.
module hex_seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg_ah
);
  assign seg_ah = hex_to_seg_ah(nibble);
endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scanner: BLANK gap then SHOW dwell per digit,
// digit value and mask snapshotted on entry to SHOW, frame pulse on index wrap.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS      = 2,
  parameter int TICKS_PER_DIGIT = 50000,
  parameter int BLANK_TICKS     = 600,
  parameter int SEG_ACTIVE_LOW  = 1,
  parameter int EN_ACTIVE_LOW   = 1
) (
  input  logic                                                clk,
  input  logic                                                reset,
  input  logic [4*NUM_DIGITS-1:0]                             digits,
  input  logic [NUM_DIGITS-1:0]                               blank_mask,
  output logic [6:0]                                          seg,
  output logic [NUM_DIGITS-1:0]                               en,
  output logic [(NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx,
  output logic                                                frame_tick
);
  localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CMAX = (TICKS_PER_DIGIT > BLANK_TICKS)
                      ? ((TICKS_PER_DIGIT > 2) ? TICKS_PER_DIGIT : 2)
                      : ((BLANK_TICKS > 2) ? BLANK_TICKS : 2);
  localparam int CW   = $clog2(CMAX);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(TICKS_PER_DIGIT - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam bit SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam bit EN_INV  = (EN_ACTIVE_LOW != 0);
  localparam bit NO_BLANK = (BLANK_TICKS == 0);
  localparam seg_t SEG_OFF = SEG_OFF_AH ^ {7{SEG_INV}};
  localparam logic [NUM_DIGITS-1:0] EN_OFF = {NUM_DIGITS{EN_INV}};
  localparam scan_state_t RST_STATE = NO_BLANK ? SHOW : BLANK;

  scan_state_t           state, state_nxt;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx, idx_nxt;
  logic [3:0]            snap_nib, nib_d;
  logic                  snap_mask, mask_d;
  logic                  fresh;
  logic                  show_last, blank_last, load;
  seg_t                  seg_ah_d;
  logic [NUM_DIGITS-1:0] en_ah_d;

  assign show_last  = (state == SHOW)  && (cnt == SHOW_LAST);
  assign blank_last = (state == BLANK) && (cnt == BLANK_LAST);
  assign idx_nxt    = show_last ? ((idx == IDX_LAST) ? '0 : idx + 1'b1) : idx;
  // Without a gap there is no BLANK to snapshot from, so load on the first
  // cycle out of reset and at every dwell boundary instead.
  assign load       = NO_BLANK ? (fresh || show_last) : blank_last;
  assign nib_d      = load ? 4'(digits >> {idx_nxt, 2'b00}) : snap_nib;
  assign mask_d     = load ? 1'(blank_mask >> idx_nxt) : snap_mask;
  assign en_ah_d    = NUM_DIGITS'(1) << idx_nxt;
  assign digit_idx  = idx;

  always_comb begin
    state_nxt = state;
    if (blank_last)                 state_nxt = SHOW;
    else if (show_last && !NO_BLANK) state_nxt = BLANK;
  end

  // Decoding the next snapshot lets seg and en land in the same edge as the
  // state change, so en never leads a valid segment pattern.
  hex_seg_decoder u_dec (
    .nibble (nib_d),
    .seg_ah (seg_ah_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RST_STATE;
      cnt        <= '0;
      idx        <= '0;
      snap_nib   <= '0;
      snap_mask  <= 1'b1;
      fresh      <= 1'b1;
      seg        <= SEG_OFF;
      en         <= EN_OFF;
      frame_tick <= 1'b0;
    end else begin
      fresh      <= 1'b0;
      state      <= state_nxt;
      cnt        <= (show_last || blank_last) ? '0 : cnt + 1'b1;
      idx        <= idx_nxt;
      snap_nib   <= nib_d;
      snap_mask  <= mask_d;
      frame_tick <= show_last && (idx == IDX_LAST);
      if (state_nxt == SHOW) begin
        seg <= seg_ah_d ^ {7{SEG_INV}};
        en  <= mask_d ? EN_OFF : (en_ah_d ^ EN_OFF);
      end else begin
        seg <= SEG_OFF;
        en  <= EN_OFF;
      end
    end
  end
endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Parametrised time-multiplexed driver for N common-anode/cathode seven-segment digits sharing one segment bus.
- Cycles through digits at a fixed per-digit dwell time, with a programmable blanking gap between digits to suppress ghosting.
- Supports per-digit blanking, a digit snapshot taken at the start of each dwell, and a frame pulse.
- Sits between the board oscillator domain and the display pins; replaces the two-display hand-wired multiplexing.

Parameters:
- NUM_DIGITS, 2: number of multiplexed digits; must be >= 1.
- TICKS_PER_DIGIT, 50000: clk cycles each digit is driven (SHOW dwell); must be >= 1.
- BLANK_TICKS, 600: clk cycles with all enables off before each SHOW; 0 removes the BLANK state.
- SEG_ACTIVE_LOW, 1: 1 = segment lines low-true.
- EN_ACTIVE_LOW, 1: 1 = digit enables low-true.

Ports:
- clk  input  1  system clock (6 MHz HSOSC)
- reset  input  1  synchronous, active-high reset
- digits  input  4*NUM_DIGITS  hex nibble per digit; digit k = digits[4k+3:4k]
- blank_mask  input  NUM_DIGITS  1 = digit k stays dark during its window
- seg  output  7  segment bus {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
- en  output  NUM_DIGITS  one-hot digit enables, polarity per EN_ACTIVE_LOW
- digit_idx  output  $clog2(NUM_DIGITS) (min 1)  index of digit currently owning the bus
- frame_tick  output  1  one-cycle pulse when the index wraps to 0

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high; all state updates on the rising clk edge.
- Reset values, effective the cycle after reset is sampled high, including mid-operation:
  - state = BLANK (SHOW if BLANK_TICKS = 0), digit_idx = 0, dwell counter = 0.
  - en all inactive, seg all inactive, frame_tick = 0.
- FSM BLANK:
  - en all inactive, seg all inactive.
  - Counter runs 0..BLANK_TICKS-1; on the last count go to SHOW and clear the counter.
  - In that same cycle, snapshot digits[digit_idx] and blank_mask[digit_idx] into the display registers.
- FSM SHOW:
  - en drives only bit digit_idx active, unless the snapshotted mask bit is 1, in which case all en are inactive.
  - seg = decoded snapshot.
  - Counter runs 0..TICKS_PER_DIGIT-1. On the last count:
    - digit_idx <= (digit_idx == NUM_DIGITS-1) ? 0 : digit_idx+1.
    - Go to BLANK, or stay in SHOW with a fresh snapshot if BLANK_TICKS = 0.
- Frame period: NUM_DIGITS*(TICKS_PER_DIGIT+BLANK_TICKS) cycles.
- frame_tick is high for exactly the one cycle in which registered digit_idx first shows 0 after a wrap. It does not pulse on the first cycle out of reset.
- Masked digits keep their time slot; timing never depends on digits or blank_mask.
- Changes to digits or blank_mask during SHOW are ignored until that digit's next snapshot, so segments never glitch within a dwell.
- seg and en are registered and change in the same cycle. en never becomes active in the cycle before seg is valid for the new digit.
- NUM_DIGITS = 1: index stays 0 and frame_tick pulses every TICKS_PER_DIGIT+BLANK_TICKS cycles.
- Decode, in active-high form, bit order gfedcba:
  - 0 = 0111111, 1 = 0000110, 2 = 1011011, 3 = 1001111
  - 4 = 1100110, 5 = 1101101, 6 = 1111101, 7 = 0000111
  - 8 = 1111111, 9 = 1101111, A = 1110111, b = 1111100
  - C = 0111001, d = 1011110, E = 1111001, F = 1110001
  - Inverted when SEG_ACTIVE_LOW = 1.
- Counter width = $clog2(max(TICKS_PER_DIGIT, BLANK_TICKS, 2)); no overflow is possible.

Decomposition:
- Shared package seg_pkg:
  - seg_t (logic [6:0]).
  - State enum scan_state_t {BLANK, SHOW}.
  - Constant SEG_OFF_AH = 7'b0000000.
  - Function hex_to_seg_ah(nibble) returning the active-high pattern.
- One sub-module: hex_seg_decoder (combinational nibble -> active-high seg_t), instantiated once on the snapshot register.
- Polarity inversion is applied at the output registers.

Test Plan:
- Reset: NUM_DIGITS=3, TICKS_PER_DIGIT=4, BLANK_TICKS=2, hold reset 3 cycles, release. Required:
  - en=111 and seg=1111111 for 2 cycles.
  - Then en=110 with seg=1000000 (digit 0 = 0) for 4 cycles.
  - digit_idx sequence 0,1,2,0.
  - frame_tick high once every 18 cycles.
- Decode sweep: digits={4'h8,4'hA,4'h3}, same params, active-low. Required windows:
  - idx0 seg=0110000, en=110.
  - idx1 seg=0001000, en=101.
  - idx2 seg=0000000, en=011.
- Snapshot stability: change digit 0 from 5 to 6 at cycle 2 of its SHOW. Required:
  - seg stays 0010010 for the rest of that window.
  - 0000010 appears at digit 0's next window.
- Blank mask: blank_mask=010. Required:
  - en stays 111 during idx1's window.
  - idx0 and idx2 windows are unchanged and frame period is still 18 cycles.
- BLANK_TICKS=0, NUM_DIGITS=1, TICKS_PER_DIGIT=3. Required:
  - en held at 0 (active) continuously.
  - frame_tick every 3 cycles.
  - A new digit value appears within 3 cycles.
- Mid-dwell reset: assert reset during idx2 SHOW cycle 1. Required:
  - Next cycle en=111, seg=1111111, digit_idx=0, frame_tick=0.
  - Sequence restarts exactly as in the reset scenario.
